sdram_arbiter: RTL and testbench

Two-requester arbiter that shares the single Avalon-MM SDRAM master port between the `sdram_master` copy engine (port 0) and a second requester such as the accelerator weight fetcher (port 1). Commands are granted round-robin and held stable across `waitrequest`. Read responses are routed back to the issuing requester in order, via an internal FIFO of requester IDs. No latency is added on the command or response paths.

---
 rtl/sdram_arb_pkg.sv | 8 +
 rtl/id_fifo.sv | 56 +++++
 rtl/sdram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter.
package sdram_arb_pkg;
    localparam int unsigned NUM_REQ = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    typedef enum logic {ARB_UNLOCKED, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/id_fifo.sv
// FIFO of requester IDs for reads in flight; head names the owner of the next returning beat.
module id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  req_id_t                 push_id,
    input  logic                    pop,
    output req_id_t                 head_id,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head_id = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master between two requesters,
// with commands pinned across waitrequest and read data routed back in issue order.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [ADDR_W-1:0]  s_addr [NUM_REQ];
    logic [DATA_W-1:0]  s_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] s_rd, s_wr, elig, waitreq, rdv;

    arb_state_t state, state_nxt;
    req_id_t    lock_id, lock_id_nxt;
    req_id_t    last_grant, last_grant_nxt;
    req_id_t    grant_id;
    logic       grant_valid;
    logic       accept;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    req_id_t           head_id;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign s_addr[0]  = s0_address;
    assign s_addr[1]  = s1_address;
    assign s_wdata[0] = s0_writedata;
    assign s_wdata[1] = s1_writedata;
    assign s_rd       = {s1_read, s0_read};
    assign s_wr       = {s1_write, s0_write};

    // Eligibility looks only at the registered count, so a coinciding pop does not free a slot.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = s_wr[i] | (s_rd[i] & (fifo_count < CNT_W'(MAX_OUTSTANDING)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_UNLOCKED;
            lock_id    <= '0;
            last_grant <= req_id_t'(1);
        end else begin
            state      <= state_nxt;
            lock_id    <= lock_id_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        lock_id_nxt    = lock_id;
        last_grant_nxt = last_grant;
        grant_valid    = 1'b0;
        grant_id       = '0;
        master_read    = 1'b0;
        master_write   = 1'b0;
        accept         = 1'b0;

        if (state == ARB_LOCKED) begin
            grant_valid = 1'b1;
            grant_id    = lock_id;
        end else if (elig[0] && elig[1]) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
        end else if (elig[0]) begin
            grant_valid = 1'b1;
            grant_id    = req_id_t'(0);
        end else if (elig[1]) begin
            grant_valid = 1'b1;
            grant_id    = req_id_t'(1);
        end

        master_read  = grant_valid & s_rd[grant_id];
        master_write = grant_valid & s_wr[grant_id];
        accept       = (master_read | master_write) & ~master_waitrequest;

        if (accept) begin
            state_nxt      = ARB_UNLOCKED;
            last_grant_nxt = grant_id;
        end else if (master_read || master_write) begin
            state_nxt   = ARB_LOCKED;
            lock_id_nxt = grant_id;
        end
    end

    // Address/data lines keep their last driven value while nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_valid) begin
            addr_q  <= s_addr[grant_id];
            wdata_q <= s_wdata[grant_id];
        end
    end

    assign master_address   = grant_valid ? s_addr[grant_id] : addr_q;
    assign master_writedata = grant_valid ? s_wdata[grant_id] : wdata_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            waitreq[i] = ~(accept && (grant_id == req_id_t'(i)));
            rdv[i]     = master_readdatavalid & ~fifo_empty & (head_id == req_id_t'(i));
        end
    end

    assign s0_waitrequest   = waitreq[0];
    assign s1_waitrequest   = waitreq[1];
    assign s0_readdatavalid = rdv[0];
    assign s1_readdatavalid = rdv[1];
    assign s0_readdata      = master_readdata;
    assign s1_readdata      = master_readdata;

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept & master_read & ~fifo_full),
        .push_id (grant_id),
        .pop     (master_readdatavalid),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; expected read owners are queued when reads are issued.
module tb_sdram_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] s0_address, s1_address;
    logic              s0_read, s0_write, s1_read, s1_write;
    logic [DATA_W-1:0] s0_writedata, s1_writedata;
    logic              s0_waitrequest, s1_waitrequest;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic              s0_readdatavalid, s1_readdatavalid;
    logic [ADDR_W-1:0] master_address;
    logic              master_read, master_write;
    logic [DATA_W-1:0] master_writedata;
    logic              master_waitrequest;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;

    int tests = 0;
    int fails = 0;
    bit sb_q[$];

    sdram_arbiter #(
        .MAX_OUTSTANDING (4),
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s0_address           (s0_address),
        .s0_read              (s0_read),
        .s0_write             (s0_write),
        .s0_writedata         (s0_writedata),
        .s0_waitrequest       (s0_waitrequest),
        .s0_readdata          (s0_readdata),
        .s0_readdatavalid     (s0_readdatavalid),
        .s1_address           (s1_address),
        .s1_read              (s1_read),
        .s1_write             (s1_write),
        .s1_writedata         (s1_writedata),
        .s1_waitrequest       (s1_waitrequest),
        .s1_readdata          (s1_readdata),
        .s1_readdatavalid     (s1_readdatavalid),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        master_waitrequest = 1'b0; master_readdatavalid = 1'b0;
    endtask

    task automatic set_read(input int p, input logic v, input logic [31:0] a);
        if (p == 0) begin
            s0_read = v; s0_address = a;
        end else begin
            s1_read = v; s1_address = a;
        end
    endtask

    function automatic logic wr_of(input int p);
        return (p == 0) ? s0_waitrequest : s1_waitrequest;
    endfunction

    // Called after a settled return beat; checks routing against the queued owner.
    task automatic chk_return(input string tag, input logic [31:0] data);
        bit p;
        chk1({tag, "_sb_nonempty"}, sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
            p = sb_q.pop_front();
            chk1({tag, "_rdv0"}, s0_readdatavalid, p == 1'b0);
            chk1({tag, "_rdv1"}, s1_readdatavalid, p == 1'b1);
            chk32({tag, "_data"}, (p == 1'b0) ? s0_readdata : s1_readdata, data);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_mrd"}, master_read, 1'b0);
        chk1({tag, "_mwr"}, master_write, 1'b0);
        chk32({tag, "_maddr"}, master_address, 32'h0);
        chk32({tag, "_mwdata"}, master_writedata, 32'h0);
        chk1({tag, "_wr0"}, s0_waitrequest, 1'b1);
        chk1({tag, "_wr1"}, s1_waitrequest, 1'b1);
        chk1({tag, "_rdv0"}, s0_readdatavalid, 1'b0);
        chk1({tag, "_rdv1"}, s1_readdatavalid, 1'b0);
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] tags [5];
        rst_n = 1'b0;
        s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
        master_readdata = '0;
        idle();
        adv();
        settle();
        chk_reset_outputs("reset");
        adv();
        rst_n = 1'b1;

        // Contention: both write continuously, port 0 first after reset.
        s0_write = 1'b1; s0_address = 32'h2222DDD0; s0_writedata = 32'h0000_0100;
        s1_write = 1'b1; s1_address = 32'h3333_0000; s1_writedata = 32'h0000_0200;
        for (int k = 0; k < 6; k++) begin
            settle();
            exp_addr = (k % 2 == 0) ? 32'h2222DDD0 : 32'h3333_0000;
            chk32("rr_addr", master_address, exp_addr);
            chk32("rr_wdata", master_writedata, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk1("rr_mwr", master_write, 1'b1);
            chk1("rr_wr0", s0_waitrequest, k % 2 != 0);
            chk1("rr_wr1", s1_waitrequest, k % 2 == 0);
            adv();
        end
        idle();

        // Single read on port 0, data returns three cycles after acceptance.
        set_read(0, 1'b1, 32'h1111_0000);
        settle();
        chk1("rd0_mrd", master_read, 1'b1);
        chk32("rd0_addr", master_address, 32'h1111_0000);
        chk1("rd0_wr0", s0_waitrequest, 1'b0);
        chk1("rd0_wr1", s1_waitrequest, 1'b1);
        sb_q.push_back(1'b0);
        adv();
        s0_read = 1'b0; s0_address = 32'hFFFF_FFFF;
        settle();
        chk1("rd0_idle_mrd", master_read, 1'b0);
        chk32("rd0_addr_hold", master_address, 32'h1111_0000);
        chk1("rd0_early_rdv0", s0_readdatavalid, 1'b0);
        adv();
        settle();
        chk1("rd0_early2_rdv0", s0_readdatavalid, 1'b0);
        adv();
        master_readdatavalid = 1'b1; master_readdata = 32'hCEEC_BEEF;
        settle();
        chk_return("rd0_ret", 32'hCEEC_BEEF);
        adv();
        master_readdatavalid = 1'b0;

        // Lock: port 1 read stalled 5 cycles, port 0 write arrives in cycle 2.
        master_waitrequest = 1'b1;
        set_read(1, 1'b1, 32'h4444_0000);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                s0_write = 1'b1; s0_address = 32'h2222DDD0; s0_writedata = 32'h0000_0300;
            end
            settle();
            chk32("lock_addr", master_address, 32'h4444_0000);
            chk1("lock_mrd", master_read, 1'b1);
            chk1("lock_mwr", master_write, 1'b0);
            chk1("lock_wr1", s1_waitrequest, 1'b1);
            chk1("lock_wr0", s0_waitrequest, 1'b1);
            adv();
        end
        master_waitrequest = 1'b0;
        settle();
        chk32("unlock_addr", master_address, 32'h4444_0000);
        chk1("unlock_wr1", s1_waitrequest, 1'b0);
        chk1("unlock_wr0", s0_waitrequest, 1'b1);
        sb_q.push_back(1'b1);
        adv();
        s1_read = 1'b0;
        settle();
        chk32("after_lock_addr", master_address, 32'h2222DDD0);
        chk1("after_lock_mwr", master_write, 1'b1);
        chk1("after_lock_wr0", s0_waitrequest, 1'b0);
        adv();
        s0_write = 1'b0;
        master_readdatavalid = 1'b1; master_readdata = 32'h5555_5555;
        settle();
        chk_return("lock_ret", 32'h5555_5555);
        adv();
        master_readdatavalid = 1'b0;

        // Fill the ID FIFO with four alternating reads.
        for (int k = 0; k < 4; k++) begin
            set_read(k % 2, 1'b1, 32'h6000_0000 + 32'(k));
            settle();
            chk1("fill_wr", wr_of(k % 2), 1'b0);
            chk1("fill_mrd", master_read, 1'b1);
            sb_q.push_back(k % 2 == 1);
            adv();
            set_read(k % 2, 1'b0, 32'h0);
        end
        set_read(0, 1'b1, 32'h6666_0000);
        s1_write = 1'b1; s1_address = 32'h7777_0000;
        settle();
        chk1("full_rd_wr0", s0_waitrequest, 1'b1);
        chk1("full_wrt_wr1", s1_waitrequest, 1'b0);
        chk1("full_mwr", master_write, 1'b1);
        chk1("full_mrd", master_read, 1'b0);
        chk32("full_addr", master_address, 32'h7777_0000);
        adv();
        s1_write = 1'b0;
        settle();
        chk1("full_only_wr0", s0_waitrequest, 1'b1);
        chk1("full_only_mrd", master_read, 1'b0);
        adv();

        // Drain; the pending port 0 read may only go once the registered count drops.
        tags[0] = 32'hA0; tags[1] = 32'hA1; tags[2] = 32'hA2; tags[3] = 32'hA3; tags[4] = 32'hA4;
        for (int k = 0; k < 5; k++) begin
            master_readdatavalid = 1'b1; master_readdata = tags[k];
            settle();
            chk_return("drain", tags[k]);
            if (k == 0) begin
                chk1("full_pop_wr0", s0_waitrequest, 1'b1);
            end else if (k == 1) begin
                chk1("pushpop_wr0", s0_waitrequest, 1'b0);
                sb_q.push_back(1'b0);
            end
            adv();
            if (k == 1) s0_read = 1'b0;
        end
        settle();
        chk1("empty_drop_rdv0", s0_readdatavalid, 1'b0);
        chk1("empty_drop_rdv1", s1_readdatavalid, 1'b0);
        adv();
        master_readdatavalid = 1'b0;

        // Reset with two reads in flight; their beats must be dropped.
        set_read(0, 1'b1, 32'h8888_0000);
        adv();
        set_read(0, 1'b0, 32'h0);
        set_read(1, 1'b1, 32'h9999_0000);
        adv();
        idle();
        rst_n = 1'b0;
        settle();
        chk_reset_outputs("midrst");
        adv();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            master_readdatavalid = 1'b1; master_readdata = 32'hDEAD_0000 + 32'(k);
            settle();
            chk_reset_outputs("post_rst_beat");
            adv();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
